fifo_sync_level: RTL



---
 rtl/fifo_sync_level.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with extra-bit pointers, fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable FWFT read mode.
module fifo_sync_level #(
    parameter int MEMORY_WIDTH    = 8,
    parameter int ADDRESS_SIZE    = 3,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    input  logic                    err_clr,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    rvalid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int MEMORY_DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] AF_TH = (ADDRESS_SIZE + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDRESS_SIZE:0] AE_TH = (ADDRESS_SIZE + 1)'(ALMOST_EMPTY_TH);

    logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic [ADDRESS_SIZE:0]   wr_ptr;
    logic [ADDRESS_SIZE:0]   rd_ptr;
    logic [ADDRESS_SIZE:0]   wr_ptr_nxt;
    logic [ADDRESS_SIZE:0]   rd_ptr_nxt;
    logic [ADDRESS_SIZE:0]   count_nxt;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [ADDRESS_SIZE-1:0] rd_addr;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    full_nxt;
    logic                    empty_nxt;

    assign wr_addr = wr_ptr[ADDRESS_SIZE-1:0];
    assign rd_addr = rd_ptr[ADDRESS_SIZE-1:0];

    // Acceptance uses the registered flags; derive next pointers, count and flags.
    always_comb begin
        wr_acc     = w_en & ~full;
        rd_acc     = r_en & ~empty;
        wr_ptr_nxt = wr_ptr + {{ADDRESS_SIZE{1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{ADDRESS_SIZE{1'b0}}, rd_acc};
        count_nxt  = count + {{ADDRESS_SIZE{1'b0}}, wr_acc}
                           - {{ADDRESS_SIZE{1'b0}}, rd_acc};
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[ADDRESS_SIZE] != rd_ptr_nxt[ADDRESS_SIZE]) &&
                     (wr_ptr_nxt[ADDRESS_SIZE-1:0] == rd_ptr_nxt[ADDRESS_SIZE-1:0]);
    end

    // Pointer, level and status-flag registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= empty_nxt;
            full         <= full_nxt;
            almost_full  <= (count_nxt >= AF_TH);
            almost_empty <= (count_nxt <= AE_TH);
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow     <= (w_en & full)  | (overflow  & ~err_clr);
            underflow    <= (r_en & empty) | (underflow & ~err_clr);
        end
    end

    // Storage array; not cleared by reset, writes blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_addr] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown combinationally; forced to zero while empty so
            // stale array contents never appear after reset.
            assign rdata  = empty ? '0 : mem[rd_addr];
            assign rvalid = ~empty;
        end else begin : g_std
            // Registered read: data lands one cycle after an accepted pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc) begin
                        rdata <= mem[rd_addr];
                    end
                end
            end
        end
    endgenerate

endmodule
